sound_player: RTL and testbench

SOUND_PLAYER -- requirements
Module: sound_player

---
 rtl/sound_player.sv | 171 +++++++++++++++++
 tb/tb_sound_player.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sound_player.sv
// Piezo sound sequencer: plays a note or a short melody of fixed-length tone segments, then pulses stop.
// Define SOUND_GAP_EN to insert a silent gap of GAP_CYCLES between consecutive segments.
module sound_player #(
  parameter int unsigned SEG_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES = 2_500_000,
  parameter int unsigned TONE_SHIFT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       check,
  input  logic [3:0] sound,
  output logic       stop,
  output logic       buzzer,
  output logic       busy,
  output logic [3:0] note
);

`ifdef SOUND_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, TONE = 2'd1, DONE = 2'd2, GAP = 2'd3} state_t;
  localparam logic [23:0] GAP_LAST = 24'(GAP_CYCLES - 1);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, TONE = 2'd1, DONE = 2'd2} state_t;
`endif

  localparam logic [23:0] SEG_LAST = 24'(SEG_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  code_q;
  logic [1:0]  seg_idx_q;
  logic [23:0] seg_cnt_q;
  logic [16:0] tone_cnt_q;
  logic        buzz_q;

  logic [3:0]  cur_note;
  logic [16:0] hp_last;
  logic        seg_done, last_seg, valid_code, restart_tone, seg_run;

  // Note played in segment idx of melody code c.
  function automatic logic [3:0] seg_note(input logic [3:0] c, input logic [1:0] idx);
    seg_note = c;
    case (c)
      4'd9:  seg_note = (idx == 2'd0) ? 4'd3 : 4'd1;
      4'd10: case (idx)
               2'd0:    seg_note = 4'd1;
               2'd1:    seg_note = 4'd3;
               default: seg_note = 4'd5;
             endcase
      4'd11: case (idx)
               2'd0:    seg_note = 4'd1;
               2'd1:    seg_note = 4'd3;
               2'd2:    seg_note = 4'd5;
               default: seg_note = 4'd8;
             endcase
      4'd12: case (idx)
               2'd0:    seg_note = 4'd8;
               2'd1:    seg_note = 4'd5;
               2'd2:    seg_note = 4'd3;
               default: seg_note = 4'd1;
             endcase
      default: ;
    endcase
  endfunction

  function automatic logic [1:0] seg_last_idx(input logic [3:0] c);
    case (c)
      4'd9:          seg_last_idx = 2'd1;
      4'd10:         seg_last_idx = 2'd2;
      4'd11, 4'd12:  seg_last_idx = 2'd3;
      default:       seg_last_idx = 2'd0;
    endcase
  endfunction

  function automatic logic [16:0] half_period(input logic [3:0] n);
    logic [16:0] base;
    case (n)
      4'd1:    base = 17'd95420;
      4'd2:    base = 17'd85034;
      4'd3:    base = 17'd75758;
      4'd4:    base = 17'd71633;
      4'd5:    base = 17'd63776;
      4'd6:    base = 17'd56818;
      4'd7:    base = 17'd50607;
      4'd8:    base = 17'd47801;
      default: base = 17'd1;
    endcase
    half_period = base >> TONE_SHIFT;
  endfunction

  assign cur_note   = seg_note(code_q, seg_idx_q);
  assign hp_last    = half_period(cur_note) - 17'd1;
  assign seg_done   = (seg_cnt_q == SEG_LAST);
  assign last_seg   = (seg_idx_q == seg_last_idx(code_q));
  assign valid_code = (sound >= 4'd1) && (sound <= 4'd12);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (check) state_d = valid_code ? TONE : DONE;
      TONE: if (seg_done) begin
`ifdef SOUND_GAP_EN
        state_d = last_seg ? DONE : GAP;
`else
        state_d = last_seg ? DONE : TONE;
`endif
      end
`ifdef SOUND_GAP_EN
      GAP:  if (seg_cnt_q == GAP_LAST) state_d = TONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Segment counter runs inside a segment or gap and is zero everywhere else.
  always_comb begin
    seg_run = (state_q == TONE) && !seg_done;
`ifdef SOUND_GAP_EN
    if ((state_q == GAP) && (seg_cnt_q != GAP_LAST)) seg_run = 1'b1;
`endif
  end

  // Every TONE entry, including a back-to-back segment change, restarts the square wave.
  assign restart_tone = (state_d == TONE) && ((state_q != TONE) || seg_done);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q     <= 4'd0;
      seg_idx_q  <= 2'd0;
      seg_cnt_q  <= 24'd0;
      tone_cnt_q <= 17'd0;
      buzz_q     <= 1'b0;
    end else begin
      if ((state_q == IDLE) && check && valid_code) code_q <= sound;

      if (state_q == IDLE)                                seg_idx_q <= 2'd0;
      else if ((state_q == TONE) && seg_done && !last_seg) seg_idx_q <= seg_idx_q + 2'd1;

      seg_cnt_q <= seg_run ? seg_cnt_q + 24'd1 : 24'd0;

      if (restart_tone) begin
        tone_cnt_q <= 17'd0;
        buzz_q     <= 1'b0;
      end else if (state_q == TONE) begin
        if (tone_cnt_q == hp_last) begin
          tone_cnt_q <= 17'd0;
          buzz_q     <= ~buzz_q;
        end else begin
          tone_cnt_q <= tone_cnt_q + 17'd1;
        end
      end
    end
  end

  always_comb begin
    busy   = (state_q == TONE);
`ifdef SOUND_GAP_EN
    if (state_q == GAP) busy = 1'b1;
`endif
    stop   = (state_q == DONE);
    note   = (state_q == TONE) ? cur_note : 4'd0;
    buzzer = buzz_q && (state_q == TONE);
  end

endmodule

// File: tb/tb_sound_player.sv
// Scoreboard bench for sound_player: stimulus queues expected playbacks, a negedge monitor checks each at stop.
module tb_sound_player;
  localparam int SEG   = 1000;
  localparam int GAPC  = 200;
  localparam int SHIFT = 8;
`ifdef SOUND_GAP_EN
  localparam int G = GAPC;
`else
  localparam int G = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       check = 1'b0;
  logic [3:0] sound = 4'd0;
  logic       stop, buzzer, busy;
  logic [3:0] note;

  sound_player #(.SEG_CYCLES(SEG), .GAP_CYCLES(GAPC), .TONE_SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .check(check), .sound(sound),
    .stop(stop), .buzzer(buzzer), .busy(busy), .note(note)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  typedef struct {
    string name;
    int    seq;
    int    nseg;
    int    busy_cyc;
    int    gap_cyc;
    int    first_tog;
  } exp_t;

  exp_t exp_q[$];

  // seq packs the sounding notes, one nibble per segment, first note most significant.
  task automatic push(input string name, input int seq, input int nseg, input int first_tog);
    exp_t e;
    e.name      = name;
    e.seq       = seq;
    e.nseg      = nseg;
    e.gap_cyc   = (nseg > 0) ? (nseg - 1) * G : 0;
    e.busy_cyc  = nseg * SEG + e.gap_cyc;
    e.first_tog = first_tog;
    exp_q.push_back(e);
  endtask

  // Monitor: accumulates what the DUT plays and compares against the queue head at each stop.
  int         m_seq, m_nseg, m_busy, m_gap, m_first, m_age, m_bad;
  logic [3:0] prev_note = 4'd0;
  logic       prev_buz = 1'b0;

  task automatic m_clear();
    m_seq = 0; m_nseg = 0; m_busy = 0; m_gap = 0; m_first = 0; m_age = 0; m_bad = 0;
  endtask

  initial m_clear();

  always @(negedge clk) begin
    if (!reset) begin
      m_clear();
      prev_note = 4'd0;
      prev_buz  = 1'b0;
    end else begin
      if (busy) m_busy++;
      if (busy && note == 4'd0) m_gap++;
      if (buzzer && (!busy || note == 4'd0)) m_bad++;
      if (note != 4'd0 && note != prev_note) begin
        m_seq = (m_seq << 4) | int'(note);
        m_nseg++;
        m_age = 0;
      end else begin
        m_age++;
      end
      if (m_nseg == 1 && m_first == 0 && buzzer != prev_buz) m_first = m_age;
      if (stop) begin
        check_val("stop_with_busy", int'(busy), 0);
        check_val("stop_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check_val({e.name, "_notes"},     m_seq,   e.seq);
          check_val({e.name, "_segments"},  m_nseg,  e.nseg);
          check_val({e.name, "_busy_cyc"},  m_busy,  e.busy_cyc);
          check_val({e.name, "_gap_cyc"},   m_gap,   e.gap_cyc);
          check_val({e.name, "_first_tog"}, m_first, e.first_tog);
          check_val({e.name, "_quiet"},     m_bad,   0);
        end
        m_clear();
      end
      prev_note = note;
      prev_buz  = buzzer;
    end
  end

  task automatic start(input logic [3:0] code);
    @(negedge clk);
    sound = code;
    check = 1'b1;
  endtask

  task automatic wait_stop(input string name, input int budget);
    int n = 0;
    while (!stop && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val({name, "_stop_seen"}, int'(stop), 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_val("rst_stop",   int'(stop),   0);
    check_val("rst_buzzer", int'(buzzer), 0);
    check_val("rst_busy",   int'(busy),   0);
    check_val("rst_note",   int'(note),   0);
    #2 reset = 1'b1;

    // Single note: busy/note on the next cycle, stop 1000 cycles after entry.
    push("note1", 'h1, 1, 372);
    start(4'd1);
    @(negedge clk);
    check_val("note1_busy", int'(busy), 1);
    check_val("note1_note", int'(note), 1);
    wait_stop("note1", 1100);
    check = 1'b0;

    push("win", 'h1358, 4, 372);
    start(4'd11);
    wait_stop("win", 5000);
    check = 1'b0;

    push("invalid", 0, 0, 0);
    start(4'd14);
    wait_stop("invalid", 2);
    check = 1'b0;

    // Code change mid-playback must not disturb the running melody.
    push("levelup", 'h135, 3, 372);
    start(4'd10);
    repeat (500) @(negedge clk);
    sound = 4'd2;
    wait_stop("levelup", 4000);
    check = 1'b0;

    // Asynchronous reset mid-tone: outputs drop immediately, the request is abandoned.
    start(4'd5);
    repeat (300) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("arst_busy",   int'(busy),   0);
    check_val("arst_note",   int'(note),   0);
    check_val("arst_buzzer", int'(buzzer), 0);
    check_val("arst_stop",   int'(stop),   0);
    check = 1'b0;
    sound = 4'd0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    repeat (5) @(negedge clk);
    check_val("no_resume_busy", int'(busy), 0);

    push("note5", 'h5, 1, 249);
    start(4'd5);
    @(negedge clk);
    check_val("restart_note", int'(note), 5);
    wait_stop("note5", 1100);
    check = 1'b0;

    // check held through stop replays the same code.
    push("retrig_a", 'h31, 2, 295);
    push("retrig_b", 'h31, 2, 295);
    start(4'd9);
    wait_stop("retrig_a", 3000);
    n = 0;
    while (!busy && n < 3) begin
      @(negedge clk);
      n++;
    end
    check_val("retrig_started", int'(busy), 1);
    check = 1'b0;
    wait_stop("retrig_b", 3000);

    push("gameover", 'h8531, 4, 186);
    start(4'd12);
    wait_stop("gameover", 5000);
    check = 1'b0;

    repeat (10) @(negedge clk);
    check_val("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
